// File: rtl/fp_multiply_top.sv
// fp_multiply_top: binary32 multiplier, three-stage pipeline.
// Stage 1 unpacks and classifies the operands. Stage 2 forms the sign,
// the biased exponent sum and the 48-bit significand product.
// Stage 3 normalizes, rounds to nearest-even and applies special results.
// Subnormal inputs are treated as zero and subnormal results flush to zero.
module fp_multiply_top (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] product_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Class of one operand as {nan, inf, zero}; exp==0 counts as zero (flush).
    function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [2:0] c;
        if (e == 8'hFF) begin
            c = (f != 23'd0) ? 3'b100 : 3'b010;
        end else if (e == 8'h00) begin
            c = 3'b001;
        end else begin
            c = 3'b000;
        end
        return c;
    endfunction

    // Stage 1 registers
    logic        s1_sign_a_r, s1_sign_b_r;
    logic [7:0]  s1_exp_a_r, s1_exp_b_r;
    logic [22:0] s1_frac_a_r, s1_frac_b_r;
    logic [2:0]  s1_cls_a_r, s1_cls_b_r;

    // Stage 2 registers
    logic               s2_sign_r;
    logic signed [9:0]  s2_exp_r;
    logic [47:0]        s2_prod_r;
    logic               s2_nan_r, s2_inf_r, s2_zero_r;

    // Stage 2 combinational signals
    logic [23:0]        sig_a_s, sig_b_s;
    logic [47:0]        prod_s;
    logic signed [9:0]  exp_sum_s;
    logic               nan_s, inf_s, zero_s;

    // Stage 3 combinational signals
    logic [22:0]        mant_s;
    logic               guard_s, round_s, sticky_s, round_up_s;
    logic signed [9:0]  exp_norm_s, exp_final_s;
    logic [23:0]        mant_rnd_s;
    logic [22:0]        frac_final_s;
    logic [31:0]        result_s;

    // Stage 1: capture operands and classify them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_sign_a_r <= 1'b0;
            s1_sign_b_r <= 1'b0;
            s1_exp_a_r  <= 8'd0;
            s1_exp_b_r  <= 8'd0;
            s1_frac_a_r <= 23'd0;
            s1_frac_b_r <= 23'd0;
            s1_cls_a_r  <= 3'b000;
            s1_cls_b_r  <= 3'b000;
        end else begin
            s1_sign_a_r <= a_i[31];
            s1_sign_b_r <= b_i[31];
            s1_exp_a_r  <= a_i[30:23];
            s1_exp_b_r  <= b_i[30:23];
            s1_frac_a_r <= a_i[22:0];
            s1_frac_b_r <= b_i[22:0];
            s1_cls_a_r  <= classify(a_i[30:23], a_i[22:0]);
            s1_cls_b_r  <= classify(b_i[30:23], b_i[22:0]);
        end
    end

    // Stage 2 datapath: significand product, exponent sum, special-case flags.
    always_comb begin
        sig_a_s   = {1'b1, s1_frac_a_r};
        sig_b_s   = {1'b1, s1_frac_b_r};
        prod_s    = {24'd0, sig_a_s} * {24'd0, sig_b_s};
        exp_sum_s = $signed({2'b00, s1_exp_a_r}) + $signed({2'b00, s1_exp_b_r}) - 10'sd127;
        // Infinity times zero is invalid and folds into the NaN case.
        nan_s  = s1_cls_a_r[2] | s1_cls_b_r[2]
               | (s1_cls_a_r[1] & s1_cls_b_r[0])
               | (s1_cls_a_r[0] & s1_cls_b_r[1]);
        inf_s  = s1_cls_a_r[1] | s1_cls_b_r[1];
        zero_s = s1_cls_a_r[0] | s1_cls_b_r[0];
    end

    // Stage 2 register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_sign_r <= 1'b0;
            s2_exp_r  <= 10'sd0;
            s2_prod_r <= 48'd0;
            s2_nan_r  <= 1'b0;
            s2_inf_r  <= 1'b0;
            s2_zero_r <= 1'b0;
        end else begin
            s2_sign_r <= s1_sign_a_r ^ s1_sign_b_r;
            s2_exp_r  <= exp_sum_s;
            s2_prod_r <= prod_s;
            s2_nan_r  <= nan_s;
            s2_inf_r  <= inf_s;
            s2_zero_r <= zero_s;
        end
    end

    // Stage 3 datapath: normalize, round to nearest-even, select special results.
    always_comb begin
        mant_s       = 23'd0;
        guard_s      = 1'b0;
        round_s      = 1'b0;
        sticky_s     = 1'b0;
        exp_norm_s   = s2_exp_r;
        exp_final_s  = s2_exp_r;
        frac_final_s = 23'd0;
        result_s     = 32'd0;

        if (s2_prod_r[47]) begin
            mant_s     = s2_prod_r[46:24];
            guard_s    = s2_prod_r[23];
            round_s    = s2_prod_r[22];
            sticky_s   = |s2_prod_r[21:0];
            exp_norm_s = s2_exp_r + 10'sd1;
        end else begin
            mant_s     = s2_prod_r[45:23];
            guard_s    = s2_prod_r[22];
            round_s    = s2_prod_r[21];
            sticky_s   = |s2_prod_r[20:0];
            exp_norm_s = s2_exp_r;
        end

        round_up_s = guard_s & (round_s | sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};

        // A carry out of the fraction means the significand reached 2.0.
        if (mant_rnd_s[23]) begin
            frac_final_s = 23'd0;
            exp_final_s  = exp_norm_s + 10'sd1;
        end else begin
            frac_final_s = mant_rnd_s[22:0];
            exp_final_s  = exp_norm_s;
        end

        if (s2_nan_r) begin
            result_s = QNAN;
        end else if (s2_inf_r) begin
            result_s = {s2_sign_r, 8'hFF, 23'd0};
        end else if (s2_zero_r) begin
            result_s = {s2_sign_r, 31'd0};
        end else if (exp_final_s >= 10'sd255) begin
            result_s = {s2_sign_r, 8'hFF, 23'd0};
        end else if (exp_final_s <= 10'sd0) begin
            result_s = {s2_sign_r, 31'd0};
        end else begin
            result_s = {s2_sign_r, exp_final_s[7:0], frac_final_s};
        end
    end

    // Stage 3 register drives the output.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            product_o <= 32'd0;
        end else begin
            product_o <= result_s;
        end
    end

endmodule

// File: tb/tb_fp_multiply_top.sv
// Testbench for fp_multiply_top: directed cases from known products plus a
// randomized stream checked against an arithmetic reference model.
module tb_fp_multiply_top;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] product_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    fp_multiply_top dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .product_o (product_o)
    );

    always #5 clk = ~clk;

    // Reference: exact integer product of the significands, then scale down to
    // 24 significant bits with round-half-to-even on the exact remainder.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic   s;
        int     ex, ey, n, k, e;
        longint mx, my, p, q, rem, half;
        bit     nan_x, nan_y, inf_x, inf_y, zer_x, zer_y;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nan_x = (ex == 255) && (x[22:0] != 23'd0);
        nan_y = (ey == 255) && (y[22:0] != 23'd0);
        inf_x = (ex == 255) && (x[22:0] == 23'd0);
        inf_y = (ey == 255) && (y[22:0] == 23'd0);
        zer_x = (ex == 0);
        zer_y = (ey == 0);
        if (nan_x || nan_y) return 32'h7FC0_0000;
        if ((inf_x && zer_y) || (zer_x && inf_y)) return 32'h7FC0_0000;
        if (inf_x || inf_y) return {s, 8'hFF, 23'd0};
        if (zer_x || zer_y) return {s, 31'd0};
        mx = longint'(x[22:0]) + (longint'(1) << 23);
        my = longint'(y[22:0]) + (longint'(1) << 23);
        p  = mx * my;
        n  = (p >= (longint'(1) << 47)) ? 47 : 46;
        k  = n - 23;
        q  = p >> k;
        rem  = p - (q << k);
        half = longint'(1) << (k - 1);
        if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            n = n + 1;
        end
        e = ex + ey - 127 + (n - 46);
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(q)};
    endfunction

    // Random operand biased towards special values and exponent extremes.
    function automatic logic [31:0] rand_op();
        int          r;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        r = int'($urandom_range(0, 19));
        s = 1'($urandom);
        f = 23'($urandom);
        case (r)
            0:       begin e = 8'h00; f = 23'd0; end
            1:       e = 8'h00;
            2:       begin e = 8'hFF; f = 23'd0; end
            3:       begin e = 8'hFF; f = f | 23'd1; end
            4, 5:    e = 8'($urandom_range(250, 254));
            6, 7:    e = 8'($urandom_range(1, 6));
            8:       begin e = 8'($urandom_range(120, 134)); f = 23'h7FFFFF - 23'($urandom_range(0, 7)); end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    task automatic check(input string tag, input logic [31:0] expv);
        tests++;
        assert (product_o === expv)
        else begin
            fails++;
            $error("FAIL %s: product_o=%h expected=%h", tag, product_o, expv);
        end
    endtask

    // Drive one pair for one edge; the output then holds the pair pushed two steps earlier.
    task automatic apply(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expv, input string tag);
        a_i = x;
        b_i = y;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic apply_rand();
        logic [31:0] x, y;
        x = rand_op();
        y = rand_op();
        apply(x, y, ref_mul(x, y), $sformatf("rand %h*%h", x, y));
    endtask

    // One reset edge: output must read zero and stages 1-2 hold cleared contents.
    task automatic do_reset(input string tag);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check(tag, 32'h0000_0000);
        reset_i = 1'b0;
        exp_q.delete();
        tag_q.delete();
        exp_q.push_back(32'h0); tag_q.push_back("after_reset_1");
        exp_q.push_back(32'h0); tag_q.push_back("after_reset_2");
    endtask

    task automatic idle2();
        apply(32'h0, 32'h0, 32'h0, "idle");
        apply(32'h0, 32'h0, 32'h0, "idle");
    endtask

    initial begin
        reset_i = 1'b1;
        a_i = 32'h4020_0000;
        b_i = 32'h4080_0000;

        // Inputs held nonzero through reset: reset wins over capture.
        do_reset("reset_initial");
        apply(32'h4020_0000, 32'h4080_0000, 32'h4120_0000, "2.5x4");
        idle2();

        do_reset("reset_b");
        apply(32'hC040_0000, 32'h40E0_0000, 32'hC1A8_0000, "-3x7");
        idle2();

        do_reset("reset_c");
        apply(32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, "0x1");
        apply(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "-0x1");
        idle2();

        do_reset("reset_d");
        apply(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "1.5x1.5");
        idle2();

        do_reset("reset_e");
        apply(32'h3F7F_FFFF, 32'h3F7F_FFFF, 32'h3F7F_FFFE, "rne_sticky");
        apply(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, "overflow");
        apply(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero");
        apply(32'h7FA0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
        apply(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "-inf_x_2");
        apply(32'h0040_0000, 32'hC000_0000, 32'h8000_0000, "subnorm_flush");
        apply(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow");
        apply(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "1ulp_sq");
        idle2();

        // Back-to-back stream, no reset.
        apply(32'h4020_0000, 32'h4080_0000, 32'h4120_0000, "stream_0");
        apply(32'hC040_0000, 32'h40E0_0000, 32'hC1A8_0000, "stream_1");
        apply(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "stream_2");
        idle2();

        // Reset with two results in flight: they must never appear.
        apply(32'h4020_0000, 32'h4080_0000, 32'h4120_0000, "inflight_0");
        apply(32'hC040_0000, 32'h40E0_0000, 32'hC1A8_0000, "inflight_1");
        do_reset("reset_midstream");
        apply(32'h0, 32'h0, 32'h0, "no_stale_0");
        apply(32'h0, 32'h0, 32'h0, "no_stale_1");

        // Constant inputs keep the output constant.
        for (int i = 0; i < 5; i++) begin
            apply(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "hold");
        end
        idle2();

        // Randomized stream with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset("reset_random");
            end else begin
                apply_rand();
            end
        end
        idle2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
